// File: rtl/ballot_sender_if.sv
// Command channel plus voting-FSM drive pins for ballot_sender.
// master = command source / FSM side, slave = ballot_sender.
interface ballot_sender_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] cmd_d1;
  logic [3:0] cmd_d2;
  logic [3:0] digit;
  logic       valid;
  logic       start;
  logic       finish;
  logic       busy;
  logic       session_open;
  logic       cmd_err;
  logic [7:0] votes_sent;

  modport master (
    output cmd_valid, cmd_type, cmd_d1, cmd_d2,
    input  cmd_ready, digit, valid, start, finish, busy, session_open,
           cmd_err, votes_sent
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_d1, cmd_d2,
    output cmd_ready, digit, valid, start, finish, busy, session_open,
           cmd_err, votes_sent
  );
endinterface

// File: rtl/ballot_sender.sv
// Turns OPEN/VOTE/CLOSE commands into the voting FSM's digit/valid/start/finish pulses.
// Optional macro BALLOT_SENDER_FIFO_EN adds a 2-entry command FIFO ahead of the sequencer.
module ballot_sender #(
  parameter int PULSE_LEN     = 1,
  parameter int GAP_LEN       = 1,
  parameter int FINISH_PULSES = 3
) (
  input  logic           clock,
  input  logic           reset,
  ballot_sender_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, OPEN_P, OPEN_G, D1_P, D1_G, D2_P, D2_G, CF_P, CF_G, FIN_P, FIN_G
  } state_t;

  localparam logic [1:0] CMD_OPEN  = 2'd1;
  localparam logic [1:0] CMD_VOTE  = 2'd2;
  localparam logic [1:0] CMD_CLOSE = 2'd3;
  localparam logic [7:0] P_LAST    = 8'(PULSE_LEN - 1);
  localparam logic [7:0] G_LAST    = 8'(GAP_LEN - 1);
  localparam logic [2:0] F_LAST    = 3'(FINISH_PULSES - 1);

  state_t     r_state, w_state_nx;
  logic [7:0] r_timer;
  logic [2:0] r_fin_cnt;
  logic [3:0] r_d2;
  logic [3:0] r_digit;
  logic       r_valid, r_start, r_finish, r_busy, r_session_open, r_cmd_err;
  logic [7:0] r_votes;

  logic       w_go, w_reject, w_latch, w_is_pulse, w_timer_done;
  logic [1:0] w_type;
  logic [3:0] w_d1, w_d2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef BALLOT_SENDER_FIFO_EN
  logic [9:0] r_fifo_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_cnt;
  logic       w_full, w_push, w_pop;

  assign w_full        = (r_cnt == 2'd2);
  assign w_push        = bus.cmd_valid && !w_full;
  assign w_pop         = w_go;
  assign bus.cmd_ready = !w_full;
  assign w_go          = (r_state == IDLE) && (r_cnt != 2'd0);
  assign {w_type, w_d1, w_d2} = r_fifo_mem[r_rp];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_fifo_mem[r_wp] <= {bus.cmd_type, bus.cmd_d1, bus.cmd_d2};
  end
`else
  assign bus.cmd_ready = (r_state == IDLE);
  assign w_go          = bus.cmd_valid && (r_state == IDLE);
  assign w_type        = bus.cmd_type;
  assign w_d1          = bus.cmd_d1;
  assign w_d2          = bus.cmd_d2;
`endif

  assign w_is_pulse   = r_state inside {OPEN_P, D1_P, D2_P, CF_P, FIN_P};
  assign w_timer_done = w_is_pulse ? (r_timer == P_LAST) : (r_timer == G_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_reject   = 1'b0;
    w_latch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_latch = 1'b1;
          case (w_type)
            CMD_OPEN:  if (!r_session_open) w_state_nx = OPEN_P;
                       else                 w_reject   = 1'b1;
            CMD_VOTE:  if (r_session_open && (w_d1 <= 4'd9) && (w_d2 <= 4'd9))
                         w_state_nx = D1_P;
                       else
                         w_reject   = 1'b1;
            CMD_CLOSE: if (r_session_open) w_state_nx = FIN_P;
                       else                w_reject   = 1'b1;
            default:   ;
          endcase
        end
      end
      OPEN_P: if (w_timer_done) w_state_nx = OPEN_G;
      OPEN_G: if (w_timer_done) w_state_nx = IDLE;
      D1_P:   if (w_timer_done) w_state_nx = D1_G;
      D1_G:   if (w_timer_done) w_state_nx = D2_P;
      D2_P:   if (w_timer_done) w_state_nx = D2_G;
      D2_G:   if (w_timer_done) w_state_nx = CF_P;
      CF_P:   if (w_timer_done) w_state_nx = CF_G;
      CF_G:   if (w_timer_done) w_state_nx = IDLE;
      FIN_P:  if (w_timer_done) w_state_nx = FIN_G;
      FIN_G:  if (w_timer_done) w_state_nx = (r_fin_cnt == F_LAST) ? IDLE : FIN_P;
      default: w_state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so pins line up with r_state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_timer        <= 8'd0;
      r_fin_cnt      <= 3'd0;
      r_digit        <= 4'd0;
      r_valid        <= 1'b0;
      r_start        <= 1'b0;
      r_finish       <= 1'b0;
      r_busy         <= 1'b0;
      r_session_open <= 1'b0;
      r_cmd_err      <= 1'b0;
      r_votes        <= 8'd0;
    end else begin
      r_state   <= w_state_nx;
      r_timer   <= (w_state_nx != r_state) ? 8'd0 : r_timer + 8'd1;
      r_cmd_err <= w_reject;
      r_valid   <= w_state_nx inside {OPEN_P, D1_P, D2_P, CF_P};
      r_start   <= (w_state_nx == OPEN_P);
      r_finish  <= (w_state_nx == FIN_P);
      r_busy    <= (w_state_nx != IDLE);
      if (r_state == IDLE && w_state_nx == OPEN_P) begin
        r_session_open <= 1'b1;
        r_votes        <= 8'd0;
      end
      if (r_state == D2_G && w_state_nx == CF_P) r_votes <= sat_inc8(r_votes);
      if (r_state == FIN_G && w_state_nx == IDLE) r_session_open <= 1'b0;
      if (r_state == IDLE && w_state_nx == FIN_P) r_fin_cnt <= 3'd0;
      else if (r_state == FIN_G && w_state_nx == FIN_P) r_fin_cnt <= r_fin_cnt + 3'd1;
      if (r_state == IDLE && w_state_nx == D1_P) r_digit <= w_d1;
      else if (r_state == D1_G && w_state_nx == D2_P) r_digit <= r_d2;
    end
  end

  always_ff @(posedge clock) begin
    if (w_latch) r_d2 <= w_d2;
  end

  assign bus.digit        = r_digit;
  assign bus.valid        = r_valid;
  assign bus.start        = r_start;
  assign bus.finish       = r_finish;
  assign bus.busy         = r_busy;
  assign bus.session_open = r_session_open;
  assign bus.cmd_err      = r_cmd_err;
  assign bus.votes_sent   = r_votes;
endmodule

// File: tb/tb_ballot_sender.sv
// Directed bench for ballot_sender at P=1, G=1, FINISH_PULSES=3.
module tb_ballot_sender;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  ballot_sender_if bus ();

  ballot_sender #(.PULSE_LEN(1), .GAP_LEN(1), .FINISH_PULSES(3)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one command, waits (bounded) for ready, returns one cycle after acceptance.
  task automatic send(input logic [1:0] t, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_d1    = a;
    bus.cmd_d2    = b;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("send_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

`ifdef BALLOT_SENDER_FIFO_EN
  logic [3:0] vdig[$];
  int         n_start = 0;
  int         n_err_p = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid)   vdig.push_back(bus.digit);
      if (bus.start)   n_start++;
      if (bus.cmd_err) n_err_p++;
    end
  end

  initial begin
    logic [3:0] exp_dig [7];
    exp_dig = '{4'd0, 4'd5, 4'd1, 4'd1, 4'd1, 4'd3, 4'd3};
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_d1 = 4'd0; bus.cmd_d2 = 4'd0;
    tick(); tick();
    check_eq("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_eq("rst_open", {31'd0, bus.session_open}, 32'd0);
    rst = 1'b0;
    tick();
    send(2'd1, 4'd0, 4'd0);
    send(2'd2, 4'd5, 4'd1);
    send(2'd2, 4'd1, 4'd3);
    repeat (30) tick();
    check_eq("fifo_votes", {24'd0, bus.votes_sent}, 32'd2);
    check_eq("fifo_starts", n_start, 32'd1);
    check_eq("fifo_errs", n_err_p, 32'd0);
    check_eq("fifo_npulses", vdig.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < vdig.size()) check_eq($sformatf("fifo_dig%0d", i), {28'd0, vdig[i]}, {28'd0, exp_dig[i]});
    check_eq("fifo_idle", {31'd0, bus.busy}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
`else
  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_d1 = 4'd0; bus.cmd_d2 = 4'd0;
    tick(); tick();
    check_eq("rst_pins", {bus.digit, bus.valid, bus.start, bus.finish}, 32'd0);
    check_eq("rst_status", {bus.busy, bus.session_open, bus.cmd_err}, 32'd0);
    check_eq("rst_votes", {24'd0, bus.votes_sent}, 32'd0);
    check_eq("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // VOTE while closed
    send(2'd2, 4'd1, 4'd3);
    check_eq("vclosed_err", {31'd0, bus.cmd_err}, 32'd1);
    check_eq("vclosed_pins", {bus.valid, bus.start, bus.finish, bus.busy}, 32'd0);
    tick();
    check_eq("vclosed_err_clr", {31'd0, bus.cmd_err}, 32'd0);
    check_eq("vclosed_votes", {24'd0, bus.votes_sent}, 32'd0);

    // OPEN
    send(2'd1, 4'd0, 4'd0);
    check_eq("open_p", {bus.start, bus.valid, bus.busy, bus.session_open, bus.cmd_ready}, 32'b11110);
    tick();
    check_eq("open_g", {bus.start, bus.valid, bus.busy, bus.cmd_ready}, 32'b0010);
    tick();
    check_eq("open_done", {bus.busy, bus.cmd_ready, bus.session_open}, 32'b011);

    // VOTE 9,1: valid at +1,+3,+5 with digits 9,1,1
    send(2'd2, 4'd9, 4'd1);
    check_eq("v91_d1", {bus.valid, bus.digit}, {27'd0, 1'b1, 4'd9});
    tick();
    check_eq("v91_g1", {bus.valid, bus.digit}, {27'd0, 1'b0, 4'd9});
    tick();
    check_eq("v91_d2", {bus.valid, bus.digit}, {27'd0, 1'b1, 4'd1});
    check_eq("v91_votes_pre", {24'd0, bus.votes_sent}, 32'd0);
    tick();
    check_eq("v91_g2", {31'd0, bus.valid}, 32'd0);
    tick();
    check_eq("v91_cf", {bus.valid, bus.digit}, {27'd0, 1'b1, 4'd1});
    check_eq("v91_votes", {24'd0, bus.votes_sent}, 32'd1);
    tick();
    check_eq("v91_cfg", {bus.valid, bus.busy, bus.cmd_ready}, 32'b010);
    tick();
    check_eq("v91_done", {bus.busy, bus.cmd_ready}, 32'b01);

    // VOTE with digit 0xA while open
    send(2'd2, 4'hA, 4'd2);
    check_eq("vbad_err", {31'd0, bus.cmd_err}, 32'd1);
    check_eq("vbad_pins", {bus.valid, bus.start, bus.finish, bus.busy}, 32'd0);
    check_eq("vbad_votes", {24'd0, bus.votes_sent}, 32'd1);
    tick();

    // OPEN while already open
    send(2'd1, 4'd0, 4'd0);
    check_eq("reopen_err", {bus.cmd_err, bus.start, bus.valid}, 32'b100);
    tick();

    // CLOSE: finish on alternate cycles, three times
    send(2'd3, 4'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("close_fin%0d", i), {31'd0, bus.finish}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i < 5) tick();
    end
    check_eq("close_last_gap_open", {31'd0, bus.session_open}, 32'd1);
    tick();
    check_eq("close_done", {bus.session_open, bus.busy, bus.cmd_ready}, 32'b001);

    // Reset during D2_P
    send(2'd1, 4'd0, 4'd0);
    tick(); tick();
    send(2'd2, 4'd2, 4'd4);
    tick(); tick();
    check_eq("d2p_before_rst", {bus.valid, bus.digit}, {27'd0, 1'b1, 4'd4});
    rst = 1'b1;
    tick();
    check_eq("rst_mid_pins", {bus.valid, bus.digit, bus.busy, bus.session_open}, 32'd0);
    check_eq("rst_mid_votes", {24'd0, bus.votes_sent}, 32'd0);
    rst = 1'b0;
    tick();
    send(2'd2, 4'd3, 4'd3);
    check_eq("post_rst_vote_err", {bus.cmd_err, bus.valid}, 32'b10);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
`endif
endmodule
